// File: rtl/can_access_sequencer.sv
// Expands init / transmit / trim / bus-reset requests into Canakari register-write sequences.
// It drives the register address, the command lines and the write strobe, and waits for tx_irq after each frame.
module can_access_sequencer #(
  parameter int WR_PULSE   = 2,
  parameter int GAP        = 1,
  parameter int TX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_init,
  input  logic       req_tx,
  input  logic       req_trim,
  input  logic       req_rst_bus,
  input  logic       tx_irq,
  output logic [4:0] addr,
  output logic       initi,
  output logic       write,
  output logic       reset_can,
  output logic       trim,
  output logic       can_wr,
  output logic       busy,
  output logic       done,
  output logic [1:0] op,
  output logic       timeout_err
);

  localparam int CMAX0 = (TX_TIMEOUT > WR_PULSE) ? TX_TIMEOUT : WR_PULSE;
  localparam int CMAX1 = (CMAX0 > GAP) ? CMAX0 : GAP;
  localparam int CMAX  = (CMAX1 > 2) ? CMAX1 : 2;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TX_TIMEOUT - 1);

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_TX   = 2'd1;
  localparam logic [1:0] OP_TRIM = 2'd2;
  localparam logic [1:0] OP_RST  = 2'd3;
  localparam logic [3:0] CMD_IDLE = 4'b0100;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP, S_WAIT_TX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       addr_q, addr_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       pend_q, pend_d;
  logic             terr_q, terr_d;
  logic [3:0]       req_v;
  logic [1:0]       gop;
  logic             write_end;

  function automatic logic [4:0] addr_for(input logic [1:0] o, input logic [2:0] i);
    logic [4:0] a;
    a = 5'h12;
    case (o)
      OP_INIT: case (i)
        3'd0: a = 5'h0F;  3'd1: a = 5'h0E;  3'd2: a = 5'h05;  3'd3: a = 5'h04;
        3'd4: a = 5'h11;  3'd5: a = 5'h10;  default: a = 5'h12;
      endcase
      OP_RST:  a = (i == 3'd0) ? 5'h0E : 5'h12;
      default: case (i)
        3'd0: a = 5'h0C;  3'd1: a = 5'h0A;  3'd2: a = 5'h09;  3'd3: a = 5'h08;
        3'd4: a = 5'h07;  3'd5: a = 5'h0E;  default: a = 5'h0D;
      endcase
    endcase
    return a;
  endfunction

  function automatic logic [3:0] cmd_for(input logic [1:0] o);
    case (o)
      OP_INIT: return 4'b1000;
      OP_TX:   return 4'b0000;
      OP_TRIM: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] o);
    return (o == OP_RST) ? 3'd1 : 3'd6;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    op_d      = op_q;
    terr_d    = terr_q;
    req_v     = {req_rst_bus, req_trim, req_tx, req_init};
    pend_d    = pend_q | req_v;
    gop       = OP_INIT;
    write_end = 1'b0;
    case (state_q)
      S_IDLE: if (|pend_q) begin
        if (pend_q[OP_RST])       gop = OP_RST;
        else if (pend_q[OP_INIT]) gop = OP_INIT;
        else if (pend_q[OP_TX])   gop = OP_TX;
        else                      gop = OP_TRIM;
        pend_d[gop] = req_v[gop];
        state_d = S_SETUP;
        cnt_d   = '0;
        idx_d   = 3'd0;
        addr_d  = addr_for(gop, 3'd0);
        cmd_d   = cmd_for(gop);
        op_d    = gop;
        terr_d  = 1'b0;
      end
      S_SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_STROBE: if (cnt_q == WR_LAST) begin
        cnt_d = '0;
        if (GAP > 0) state_d = S_GAP;
        else         write_end = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_GAP: if (cnt_q == GAP_LAST) begin
        cnt_d     = '0;
        write_end = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      // A completion on the final count still counts as success.
      S_WAIT_TX: if (tx_irq) state_d = S_DONE;
      else if (cnt_q == TO_LAST) begin
        state_d = S_DONE;
        terr_d  = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_DONE: begin
        state_d = S_IDLE;
        cmd_d   = CMD_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (write_end) begin
      if (idx_q == last_idx(op_q)) begin
        state_d = (op_q == OP_TX || op_q == OP_TRIM) ? S_WAIT_TX : S_DONE;
      end else begin
        idx_d   = idx_q + 3'd1;
        addr_d  = addr_for(op_q, idx_q + 3'd1);
        state_d = S_SETUP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      addr_q  <= 5'd0;
      cmd_q   <= CMD_IDLE;
      op_q    <= OP_INIT;
      pend_q  <= 4'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
    end
  end

  assign addr        = addr_q;
  assign {initi, write, reset_can, trim} = cmd_q;
  assign can_wr      = (state_q == S_STROBE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign timeout_err = (state_q == S_DONE) && terr_q;
  assign op          = op_q;

endmodule

// File: tb/tb_can_access_sequencer.sv
// Directed bench for can_access_sequencer: a table of single operations, plus hand-written queueing and reset cases.
// Observed word per cycle = {busy, can_wr, done, timeout_err, addr, initi, write, reset_can, trim, op}.
module tb_can_access_sequencer;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst, req_init, req_tx, req_trim, req_rst_bus, tx_irq;
  logic [4:0] addr;
  logic       initi, write, reset_can, trim, can_wr, busy, done, timeout_err;
  logic [1:0] op;

  int n_chk = 0;
  int n_err = 0;

  can_access_sequencer #(.WR_PULSE(2), .GAP(1), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_init(req_init), .req_tx(req_tx), .req_trim(req_trim),
    .req_rst_bus(req_rst_bus), .tx_irq(tx_irq), .addr(addr), .initi(initi), .write(write),
    .reset_can(reset_can), .trim(trim), .can_wr(can_wr), .busy(busy), .done(done),
    .op(op), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [3:0]       reqs;   // {rst_bus, trim, tx, init}
    logic [1:0]       op;
    logic [3:0]       cmd;
    int               n;
    logic [0:6][4:0]  addrs;
    int               irq_at; // WAIT_TX cycle in which tx_irq is raised, -1 = never
  } rec_t;

  rec_t tbl[6];

  localparam logic [14:0] RESET_W = {4'b0000, 5'h00, 4'b0100, 2'd0};

  function automatic logic [14:0] obs();
    return {busy, can_wr, done, timeout_err, addr, initi, write, reset_can, trim, op};
  endfunction

  task automatic check(input string nm, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got busy/wr/done/err=%b addr=%h cmd=%b op=%0d, required busy/wr/done/err=%b addr=%h cmd=%b op=%0d",
               nm, got[14:11], got[10:6], got[5:2], got[1:0], exp[14:11], exp[10:6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic set_reqs(input logic [3:0] r);
    req_init = r[0]; req_tx = r[1]; req_trim = r[2]; req_rst_bus = r[3];
  endtask

  task automatic pulse_req(input logic [3:0] r);
    set_reqs(r);
    @(negedge clk);
    set_reqs(4'b0000);
  endtask

  task automatic drive_inj(input int c, input int c1, input logic [3:0] r1, input int c2, input logic [3:0] r2);
    set_reqs(((c == c1) ? r1 : 4'b0000) | ((c == c2) ? r2 : 4'b0000));
  endtask

  // Follows one operation cycle by cycle from its first busy cycle to the idle cycle after done.
  task automatic run_seq(input rec_t r, input string nm, input int c1, input logic [3:0] r1,
                         input int c2, input logic [3:0] r2);
    int  guard, c, w;
    bit  fin, err;
    logic [4:0] last;
    guard = 0;
    while (!busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!busy) begin
      n_chk++; n_err++;
      $display("FAIL %s start: busy=%b after %0d cycles, required 1", nm, busy, guard);
      return;
    end
    c = 1;
    for (int k = 0; k < r.n; k++) begin
      for (int ph = 0; ph < 5; ph++) begin
        drive_inj(c, c1, r1, c2, r2);
        check($sformatf("%s cyc%0d", nm, c), obs(),
              {1'b1, (ph == 2 || ph == 3), 2'b00, r.addrs[k], r.cmd, r.op});
        @(negedge clk);
        c++;
      end
    end
    last = r.addrs[r.n-1];
    err  = 1'b0;
    if (r.op == 2'd1 || r.op == 2'd2) begin
      w = 0; fin = 1'b0;
      while (!fin) begin
        drive_inj(c, c1, r1, c2, r2);
        check($sformatf("%s wait%0d", nm, w), obs(), {4'b1000, last, r.cmd, r.op});
        if (w == r.irq_at) begin
          tx_irq = 1'b1; fin = 1'b1;
        end else if (w == TO - 1) begin
          fin = 1'b1; err = 1'b1;
        end
        @(negedge clk);
        tx_irq = 1'b0;
        c++; w++;
      end
    end
    drive_inj(c, c1, r1, c2, r2);
    check($sformatf("%s done", nm), obs(), {3'b101, err, last, r.cmd, r.op});
    @(negedge clk);
    set_reqs(4'b0000);
    check($sformatf("%s idle", nm), obs(), {4'b0000, last, 4'b0100, r.op});
    @(negedge clk);
  endtask

  initial begin
    rec_t r;
    tbl[0] = '{"init", 4'b0001, 2'd0, 4'b1000, 7, {5'h0F,5'h0E,5'h05,5'h04,5'h11,5'h10,5'h12}, -1};
    tbl[1] = '{"rst_bus", 4'b1000, 2'd3, 4'b0010, 2, {5'h0E,5'h12,5'h00,5'h00,5'h00,5'h00,5'h00}, -1};
    tbl[2] = '{"tx", 4'b0010, 2'd1, 4'b0000, 7, {5'h0C,5'h0A,5'h09,5'h08,5'h07,5'h0E,5'h0D}, 7};
    tbl[3] = '{"trim_irq0", 4'b0100, 2'd2, 4'b0001, 7, {5'h0C,5'h0A,5'h09,5'h08,5'h07,5'h0E,5'h0D}, 0};
    tbl[4] = '{"trim_tie", 4'b0100, 2'd2, 4'b0001, 7, {5'h0C,5'h0A,5'h09,5'h08,5'h07,5'h0E,5'h0D}, TO - 1};
    tbl[5] = '{"trim_timeout", 4'b0100, 2'd2, 4'b0001, 7, {5'h0C,5'h0A,5'h09,5'h08,5'h07,5'h0E,5'h0D}, -1};

    rst = 1'b1; tx_irq = 1'b0;
    set_reqs(4'b0000);
    repeat (3) @(negedge clk);
    check("reset held", obs(), RESET_W);
    rst = 1'b0;
    @(negedge clk);
    check("reset released", obs(), RESET_W);

    for (int i = 0; i < 6; i++) begin
      pulse_req(tbl[i].reqs);
      run_seq(tbl[i], tbl[i].name, -1, 4'b0000, -1, 4'b0000);
    end

    // tx and trim requested together: tx first, trim follows on its own
    pulse_req(4'b0110);
    run_seq(tbl[2], "pair_tx", -1, 4'b0000, -1, 4'b0000);
    r = tbl[3]; r.irq_at = 3;
    run_seq(r, "pair_trim", -1, 4'b0000, -1, 4'b0000);

    // rst_bus arriving at the 3rd init write waits for init to finish
    pulse_req(4'b0001);
    run_seq(tbl[0], "init_then_rst", 11, 4'b1000, -1, 4'b0000);
    run_seq(tbl[1], "queued_rst", -1, 4'b0000, -1, 4'b0000);

    // two tx requests while busy collapse into one tx operation
    pulse_req(4'b0001);
    run_seq(tbl[0], "init_dup", 3, 4'b0010, 20, 4'b0010);
    r = tbl[2]; r.irq_at = 2;
    run_seq(r, "dup_tx", -1, 4'b0000, -1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("dup absorbed %0d", i), obs(), {4'b0000, 5'h0D, 4'b0100, 2'd1});
      @(negedge clk);
    end

    // reset during the first strobe of a tx abandons it; a new tx starts from 0C
    pulse_req(4'b0010);
    @(negedge clk);
    check("mid tx setup", obs(), {4'b1000, 5'h0C, 4'b0000, 2'd1});
    repeat (2) @(negedge clk);
    check("mid tx strobe", obs(), {4'b1100, 5'h0C, 4'b0000, 2'd1});
    rst = 1'b1;
    @(negedge clk);
    check("reset mid strobe", obs(), RESET_W);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("no done after reset %0d", i), obs(), RESET_W);
    end
    pulse_req(4'b0010);
    r = tbl[2]; r.irq_at = 1;
    run_seq(r, "tx_restart", -1, 4'b0000, -1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
